// File: rtl/cnn_pkg.sv
// Shared CNN pipeline definitions: pooled feature-map geometry, pixel word, frame buffer states.
package cnn_pkg;

    localparam int unsigned FMAP_W  = 16;
    localparam int unsigned FMAP_H  = 16;
    localparam int unsigned PIXEL_W = 32;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_DRAIN = 1'b1
    } buf_state_e;

endpackage

// File: rtl/fmap_bank_ram.sv
// Simple dual-port RAM: one write port, one enabled registered read port (1-cycle latency).
// The read register holds its value while re is low, so it can act as a pipeline stage.
module fmap_bank_ram #(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned DEPTH      = 256,
    localparam int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port, held when not enabled
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fmap_buffer_l1.sv
// Layer-1 to layer-2 frame buffer: captures four channel-parallel pooled maps without
// stalling the producer, then replays each full frame in raster order over valid/ready.
// Optional build macro FMAP_BUF_PINGPONG_EN selects two banks so filling and draining overlap.
module fmap_buffer_l1
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WIDTH      = FMAP_W,
    parameter int unsigned HEIGHT     = FMAP_H
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in0,
    input  logic [DATA_WIDTH-1:0] data_in1,
    input  logic [DATA_WIDTH-1:0] data_in2,
    input  logic [DATA_WIDTH-1:0] data_in3,
    input  logic                  out_ready,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out0,
    output logic [DATA_WIDTH-1:0] data_out1,
    output logic [DATA_WIDTH-1:0] data_out2,
    output logic [DATA_WIDTH-1:0] data_out3,
    output logic                  last_out,
    output logic                  frame_done,
    output logic                  overflow
);

    localparam int unsigned DEPTH = WIDTH * HEIGHT;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned NCH   = 4;
`ifdef FMAP_BUF_PINGPONG_EN
    localparam int unsigned NB    = 2;
`else
    localparam int unsigned NB    = 1;
`endif
    localparam logic PINGPONG = (NB == 2);

    logic [DATA_WIDTH-1:0] din     [NCH];
    logic [DATA_WIDTH-1:0] rd_data [2][NCH];
    logic [DATA_WIDTH-1:0] dout_q  [NCH];

    logic [1:0]    full;
    logic          wr_bank;
    logic [AW-1:0] wr_addr;
    logic          wr_accept;
    logic          wr_last;

    logic          rd_bank;
    logic [AW:0]   rd_addr;
    logic          rd_last;
    logic          rd_issue;

    logic          pf_valid;
    logic          pf_last;
    logic          pf_bank;
    logic          out_bank;
    logic          advance;
    logic          last_xfer;

    buf_state_e    state_q;
    buf_state_e    state_d;

    assign din[0] = data_in0;
    assign din[1] = data_in1;
    assign din[2] = data_in2;
    assign din[3] = data_in3;

    assign data_out0 = dout_q[0];
    assign data_out1 = dout_q[1];
    assign data_out2 = dout_q[2];
    assign data_out3 = dout_q[3];

    // A write lands only if the bank it targets is not holding a completed frame
    assign wr_accept = valid_in && !full[wr_bank];
    assign wr_last   = (wr_addr == AW'(DEPTH - 1));

    // Pipeline moves whenever the output register is free or being consumed
    assign advance   = !valid_out || out_ready;
    assign last_xfer = valid_out && out_ready && last_out;
    assign rd_last   = (rd_addr[AW-1:0] == AW'(DEPTH - 1));
    assign rd_issue  = full[rd_bank] && !rd_addr[AW] && advance;

    // Per-bank, per-channel storage; absent banks read as zero
    for (genvar b = 0; b < 2; b++) begin : g_bank
        if (b < NB) begin : g_ram
            for (genvar c = 0; c < NCH; c++) begin : g_ch
                fmap_bank_ram #(
                    .DATA_WIDTH(DATA_WIDTH),
                    .DEPTH     (DEPTH)
                ) u_ram (
                    .clk  (clk),
                    .we   (wr_accept && (wr_bank == 1'(b))),
                    .waddr(wr_addr),
                    .wdata(din[c]),
                    .re   (rd_issue && (rd_bank == 1'(b))),
                    .raddr(rd_addr[AW-1:0]),
                    .rdata(rd_data[b][c])
                );
            end
        end else begin : g_none
            for (genvar c = 0; c < NCH; c++) begin : g_ch
                assign rd_data[b][c] = '0;
            end
        end
    end

    // Write pointer and bank select; wraps and switches bank on the final pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_addr <= '0;
            wr_bank <= 1'b0;
        end else if (wr_accept) begin
            wr_addr <= wr_last ? '0 : wr_addr + AW'(1);
            if (wr_last) begin
                wr_bank <= wr_bank ^ PINGPONG;
            end
        end
    end

    // Bank full flags: set by the fill side, cleared on the last_out handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= '0;
        end else begin
            if (wr_accept && wr_last) begin
                full[wr_bank] <= 1'b1;
            end
            if (last_xfer) begin
                full[out_bank] <= 1'b0;
            end
        end
    end

    // Sticky drop indicator
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (valid_in && full[wr_bank]) begin
            overflow <= 1'b1;
        end
    end

    // Read pointer; with two banks it hops straight to the other bank so frames run back-to-back
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr <= '0;
            rd_bank <= 1'b0;
        end else if (rd_issue) begin
            if (rd_last && PINGPONG) begin
                rd_addr <= '0;
                rd_bank <= ~rd_bank;
            end else begin
                rd_addr <= rd_addr + (AW+1)'(1);
            end
        end else if (last_xfer && !PINGPONG) begin
            rd_addr <= '0;
        end
    end

    // Read-side state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Read-side next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (full[rd_bank]) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_xfer) begin
                    state_d = (PINGPONG && full[~out_bank]) ? ST_DRAIN : ST_EMPTY;
                end
            end
        endcase
    end

    // Prefetch stage tags that travel alongside the RAM read register
    always_ff @(posedge clk) begin
        if (reset) begin
            pf_valid <= 1'b0;
            pf_last  <= 1'b0;
            pf_bank  <= 1'b0;
        end else if (advance) begin
            pf_valid <= rd_issue;
            pf_last  <= rd_last;
            pf_bank  <= rd_bank;
        end
    end

    // Output register; everything holds while a word is stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            out_bank  <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                dout_q[c] <= '0;
            end
        end else if (advance) begin
            valid_out <= pf_valid;
            last_out  <= pf_valid && pf_last;
            if (pf_valid) begin
                out_bank <= pf_bank;
                for (int c = 0; c < NCH; c++) begin
                    dout_q[c] <= rd_data[pf_bank][c];
                end
            end
        end
    end

    // One-cycle pulse after the final word of a frame is taken
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_xfer;
        end
    end

endmodule

// File: tb/tb_fmap_buffer_l1.sv
// Directed bench for fmap_buffer_l1: single frame, backpressure, overflow or ping-pong
// (depending on FMAP_BUF_PINGPONG_EN), and reset in the middle of a frame.
module tb_fmap_buffer_l1;

    localparam int DEPTH = 256;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [31:0] din [4];
    logic        out_ready;
    logic        valid_out;
    logic [31:0] dout [4];
    logic        last_out;
    logic        frame_done;
    logic        overflow;

    int n_vec;
    int n_err;
    int cyc;
    int first_valid_cyc;
    int mark;
    int exp_idx;
    int exp_tags [$];
    logic fd_pend;
    logic stall_pend;
    logic stall_last;
    logic [31:0] stall_d [4];
    logic obs_valid;

    fmap_buffer_l1 dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in0  (din[0]),
        .data_in1  (din[1]),
        .data_in2  (din[2]),
        .data_in3  (din[3]),
        .out_ready (out_ready),
        .valid_out (valid_out),
        .data_out0 (dout[0]),
        .data_out1 (dout[1]),
        .data_out2 (dout[2]),
        .data_out3 (dout[3]),
        .last_out  (last_out),
        .frame_done(frame_done),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pix(input int c, input int tag, input int idx);
        return {8'(c), 8'(tag), 16'(idx)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: observe outputs at the falling edge, then drive inputs for the next rising edge
    task automatic cycle(input logic vin, input int tag, input int idx, input logic rdy);
        @(negedge clk);
        cyc++;
        obs_valid = valid_out;
        if (valid_out && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (stall_pend) begin
            check("stall_valid", 32'(valid_out), 32'd1);
            check("stall_last", 32'(last_out), 32'(stall_last));
            for (int c = 0; c < 4; c++) check("stall_data", dout[c], stall_d[c]);
        end
        check("frame_done", 32'(frame_done), 32'(fd_pend));
        fd_pend    = 1'b0;
        stall_pend = 1'b0;
        valid_in   = vin;
        for (int c = 0; c < 4; c++) din[c] = pix(c, tag, idx);
        out_ready  = rdy;
        if (valid_out && !rdy) begin
            stall_pend = 1'b1;
            stall_last = last_out;
            for (int c = 0; c < 4; c++) stall_d[c] = dout[c];
        end
        if (valid_out && rdy) begin
            check("valid_expected", 32'(valid_out), 32'(exp_tags.size() != 0));
            if (exp_tags.size() != 0) begin
                for (int c = 0; c < 4; c++) check("data", dout[c], pix(c, exp_tags[0], exp_idx));
                check("last_out", 32'(last_out), 32'(exp_idx == DEPTH - 1));
                if (exp_idx == DEPTH - 1) begin
                    fd_pend = 1'b1;
                    exp_idx = 0;
                    void'(exp_tags.pop_front());
                end else begin
                    exp_idx++;
                end
            end
        end
    endtask

    task automatic write_frame(input int tag, input int n, input logic rdy, input bit push);
        for (int i = 0; i < n; i++) cycle(1'b1, tag, i, rdy);
        if (push) exp_tags.push_back(tag);
    endtask

    task automatic drain(input int budget, input bit rnd);
        int steps;
        steps = 0;
        while (exp_tags.size() != 0 && steps < budget) begin
            cycle(1'b0, 0, 0, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            steps++;
        end
        check("drain_complete", 32'(exp_tags.size()), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 0, 1'b1);
    endtask

    task automatic clear_model();
        exp_tags.delete();
        exp_idx    = 0;
        fd_pend    = 1'b0;
        stall_pend = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 32'(valid_out), 32'd0);
        check({tag, "_last"}, 32'(last_out), 32'd0);
        check({tag, "_fdone"}, 32'(frame_done), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        for (int c = 0; c < 4; c++) check({tag, "_data"}, dout[c], 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        first_valid_cyc = -1;
        reset     = 1'b1;
        valid_in  = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) din[c] = '0;
        clear_model();

        // Reset state
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 0, 1'b0);
        check_zero_outputs("rst");
        reset = 1'b0;
        cycle(1'b0, 0, 0, 1'b1);

        // Single frame, out_ready high: latency, gapless drain, one frame_done
        write_frame(1, DEPTH, 1'b1, 1'b1);
        mark = cyc;
        first_valid_cyc = -1;
        drain(1000, 1'b0);
        check("t1_first_valid", 32'(first_valid_cyc - mark), 32'd3);
        check("t1_drain_cycles", 32'(cyc - 3 - mark), 32'd258);

        // Backpressure with pseudo-random out_ready
        write_frame(2, DEPTH, 1'b0, 1'b1);
        mark = cyc;
        first_valid_cyc = -1;
        drain(3000, 1'b1);
        check("t2_first_valid", 32'(first_valid_cyc - mark), 32'd3);
        check("t2_overflow", 32'(overflow), 32'd0);

`ifdef FMAP_BUF_PINGPONG_EN
        // Ping-pong: frames A and B back-to-back, B follows A with no gap
        write_frame(5, DEPTH, 1'b0, 1'b1);
        mark = cyc;
        first_valid_cyc = -1;
        write_frame(6, DEPTH, 1'b1, 1'b1);
        drain(2000, 1'b0);
        check("pp_first_valid", 32'(first_valid_cyc - mark), 32'd3);
        check("pp_drain_cycles", 32'(cyc - 3 - mark), 32'd514);
        check("pp_overflow", 32'(overflow), 32'd0);
`else
        // Overflow: second frame while the only bank is still full is dropped entirely
        write_frame(3, DEPTH, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 0, 0, 1'b0);
        check("ovf_before", 32'(overflow), 32'd0);
        write_frame(4, DEPTH, 1'b0, 1'b0);
        cycle(1'b0, 0, 0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        drain(1000, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 0, 0, 1'b1);
        check("ovf_no_residue", 32'(valid_out), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        // Write pointer must not have advanced on dropped writes
        write_frame(7, DEPTH, 1'b1, 1'b1);
        drain(1000, 1'b0);
`endif

        // Reset mid-frame: partial frame discarded, outputs zero during and after reset
        write_frame(8, 100, 1'b1, 1'b0);
        reset = 1'b1;
        clear_model();
        cycle(1'b0, 0, 0, 1'b1);
        cycle(1'b0, 0, 0, 1'b1);
        check_zero_outputs("midrst");
        reset = 1'b0;
        cycle(1'b0, 0, 0, 1'b1);
        cycle(1'b0, 0, 0, 1'b1);
        check_zero_outputs("postrst");
        write_frame(9, DEPTH, 1'b1, 1'b1);
        check("postrst_idle_data", dout[0], 32'd0);
        mark = cyc;
        first_valid_cyc = -1;
        drain(1000, 1'b0);
        check("postrst_first_valid", 32'(first_valid_cyc - mark), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
